// File: rtl/accel_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : accel_seq_ctrl
// Description : Sequencer for the accelerator loop. It fetches parameters,
//               runs up to two Occ lookups with timeout, then executes and
//               writes back until finish, abort, iteration limit or error.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_seq_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int TO_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              is_start,
    input  logic              is_abort,
    input  logic              err_clr,
    input  logic              is_find,
    input  logic              is_get_data_in_Occ,
    input  logic              is_finish,
    input  logic [ADDR_W-1:0] occ_addr_k,
    input  logic [ADDR_W-1:0] occ_addr_l,
    input  logic [TO_W-1:0]   cfg_timeout,
    input  logic [CNT_W-1:0]  cfg_max_iter,
    output logic              occ_req_valid,
    input  logic              occ_req_ready,
    output logic [ADDR_W-1:0] occ_req_addr,
    input  logic              occ_rsp_valid,
    input  logic [DATA_W-1:0] occ_rsp_data,
    output logic [3:0]        state,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] data_2,
    output logic [CNT_W-1:0]  iter_cnt,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_GET_PARAM  = 4'd1,
        ST_GET_DATA_1 = 4'd2,
        ST_GET_DATA_2 = 4'd3,
        ST_GET_DATA_3 = 4'd4,
        ST_EX         = 4'd5,
        ST_WRITE_BACK = 4'd6,
        ST_DONE       = 4'd7,
        ST_ERROR      = 4'd8
    } state_t;

    localparam logic       c_PH_REQ      = 1'b0;
    localparam logic       c_PH_RSP      = 1'b1;
    localparam logic [1:0] c_ERR_NONE    = 2'd0;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] c_ERR_ITER    = 2'd2;

    state_t              r_state;
    logic                r_phase;
    logic                r_req_valid;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [DATA_W-1:0]   r_data_1;
    logic [DATA_W-1:0]   r_data_2;
    logic [CNT_W-1:0]    r_iter_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic [1:0]          r_err_code;

    logic                w_abort;
    logic                w_handshake;
    logic                w_fetch_done;
    logic                w_timeout;
    logic [TO_W-1:0]     w_to_limit;
    logic [CNT_W-1:0]    w_iter_next;

    assign w_abort      = is_abort && (r_state != ST_IDLE) && (r_state != ST_ERROR);
    // Responses are only honoured once the request has been accepted.
    assign w_handshake  = (r_phase == c_PH_REQ) && r_req_valid && occ_req_ready;
    assign w_fetch_done = (r_phase == c_PH_RSP) && occ_rsp_valid;
    assign w_to_limit   = cfg_timeout - TO_W'(1);
    assign w_timeout    = (cfg_timeout != '0) && (r_to_cnt == w_to_limit);
    assign w_iter_next  = (&r_iter_cnt) ? r_iter_cnt : r_iter_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_phase     <= c_PH_REQ;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_data_1    <= '0;
            r_data_2    <= '0;
            r_iter_cnt  <= '0;
            r_to_cnt    <= '0;
            r_err_code  <= c_ERR_NONE;
        end else if (w_abort) begin
            r_state     <= ST_IDLE;
            r_phase     <= c_PH_REQ;
            r_req_valid <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (is_start) begin
                        r_state    <= ST_GET_PARAM;
                        r_iter_cnt <= '0;
                        r_data_1   <= '0;
                        r_data_2   <= '0;
                        r_err_code <= c_ERR_NONE;
                    end
                end
                ST_GET_PARAM: begin
                    r_state <= is_find ? ST_GET_DATA_1 : ST_DONE;
                end
                ST_GET_DATA_1: begin
                    if (is_get_data_in_Occ) begin
                        r_state     <= ST_GET_DATA_2;
                        r_phase     <= c_PH_REQ;
                        r_req_valid <= 1'b1;
                        r_req_addr  <= occ_addr_k;
                        r_to_cnt    <= '0;
                    end else begin
                        r_state <= ST_EX;
                    end
                end
                ST_GET_DATA_2, ST_GET_DATA_3: begin
                    if (w_fetch_done) begin
                        r_phase  <= c_PH_REQ;
                        r_to_cnt <= '0;
                        if (r_state == ST_GET_DATA_2) begin
                            r_data_1    <= occ_rsp_data;
                            r_state     <= ST_GET_DATA_3;
                            r_req_valid <= 1'b1;
                            r_req_addr  <= occ_addr_l;
                        end else begin
                            r_data_2    <= occ_rsp_data;
                            r_state     <= ST_EX;
                            r_req_valid <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state     <= ST_ERROR;
                        r_err_code  <= c_ERR_TIMEOUT;
                        r_req_valid <= 1'b0;
                        r_phase     <= c_PH_REQ;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                        if (w_handshake) begin
                            r_req_valid <= 1'b0;
                            r_phase     <= c_PH_RSP;
                        end
                    end
                end
                ST_EX: begin
                    r_state <= is_finish ? ST_DONE : ST_WRITE_BACK;
                end
                ST_WRITE_BACK: begin
                    r_iter_cnt <= w_iter_next;
                    if ((cfg_max_iter != '0) && (w_iter_next == cfg_max_iter)) begin
                        r_state    <= ST_ERROR;
                        r_err_code <= c_ERR_ITER;
                    end else begin
                        r_state <= ST_GET_PARAM;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                ST_ERROR: begin
                    if (err_clr) begin
                        r_state    <= ST_IDLE;
                        r_err_code <= c_ERR_NONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state         = r_state;
    assign occ_req_valid = r_req_valid;
    assign occ_req_addr  = r_req_addr;
    assign data_1        = r_data_1;
    assign data_2        = r_data_2;
    assign iter_cnt      = r_iter_cnt;
    assign err_code      = r_err_code;
    assign done          = (r_state == ST_DONE);
    assign error         = (r_state == ST_ERROR);
    assign busy          = (r_state == ST_GET_PARAM)  || (r_state == ST_GET_DATA_1) ||
                           (r_state == ST_GET_DATA_2) || (r_state == ST_GET_DATA_3) ||
                           (r_state == ST_EX)         || (r_state == ST_WRITE_BACK);

endmodule
`default_nettype wire

// File: tb/tb_accel_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_seq_ctrl
// Description : Directed self-checking bench for accel_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_seq_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int TO_W   = 8;

    logic              clk;
    logic              rst_n;
    logic              is_start;
    logic              is_abort;
    logic              err_clr;
    logic              is_find;
    logic              is_get_data_in_Occ;
    logic              is_finish;
    logic [ADDR_W-1:0] occ_addr_k;
    logic [ADDR_W-1:0] occ_addr_l;
    logic [TO_W-1:0]   cfg_timeout;
    logic [CNT_W-1:0]  cfg_max_iter;
    logic              occ_req_valid;
    logic              occ_req_ready;
    logic [ADDR_W-1:0] occ_req_addr;
    logic              occ_rsp_valid;
    logic [DATA_W-1:0] occ_rsp_data;
    logic [3:0]        state;
    logic [DATA_W-1:0] data_1;
    logic [DATA_W-1:0] data_2;
    logic [CNT_W-1:0]  iter_cnt;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;

    int n_checks;
    int n_errors;

    accel_seq_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .TO_W(TO_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .is_start(is_start), .is_abort(is_abort), .err_clr(err_clr),
        .is_find(is_find), .is_get_data_in_Occ(is_get_data_in_Occ),
        .is_finish(is_finish),
        .occ_addr_k(occ_addr_k), .occ_addr_l(occ_addr_l),
        .cfg_timeout(cfg_timeout), .cfg_max_iter(cfg_max_iter),
        .occ_req_valid(occ_req_valid), .occ_req_ready(occ_req_ready),
        .occ_req_addr(occ_req_addr),
        .occ_rsp_valid(occ_rsp_valid), .occ_rsp_data(occ_rsp_data),
        .state(state), .data_1(data_1), .data_2(data_2), .iter_cnt(iter_cnt),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        is_start = 0; is_abort = 0; err_clr = 0;
        is_find = 0; is_get_data_in_Occ = 0; is_finish = 0;
        occ_req_ready = 0; occ_rsp_valid = 0; occ_rsp_data = '0;
        cfg_timeout = '0; cfg_max_iter = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        occ_addr_k = 8'h12;
        occ_addr_l = 8'h34;
        rst_n = 0;
        step(); step();
        n_checks++;
        if (state !== 4'd0 || occ_req_valid !== 1'b0 || occ_req_addr !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_ctrl: state=%0d valid=%b addr=%h required 0/0/00", state, occ_req_valid, occ_req_addr);
        end
        n_checks++;
        if (data_1 !== 32'h0 || data_2 !== 32'h0 || iter_cnt !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_data: d1=%h d2=%h iter=%0d required zeros", data_1, data_2, iter_cnt);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || err_code !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_flags: busy=%b done=%b error=%b code=%0d required 0/0/0/0", busy, done, error, err_code);
        end
        rst_n = 1;
        step();
        n_checks++;
        if (state !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_release: state=%0d required 0", state);
        end
    endtask

    task automatic test_nominal();
        is_find = 1; is_get_data_in_Occ = 1; is_finish = 1; occ_req_ready = 1;
        is_start = 1;
        step(); is_start = 0;
        n_checks++;
        if (state !== 4'd1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL nom_get_param: state=%0d busy=%b required 1/1", state, busy);
        end
        step(); step();
        n_checks++;
        if (state !== 4'd3 || occ_req_valid !== 1'b1 || occ_req_addr !== 8'h12) begin
            n_errors++;
            $display("FAIL nom_req_k: state=%0d valid=%b addr=%h required 3/1/12", state, occ_req_valid, occ_req_addr);
        end
        step();
        n_checks++;
        if (state !== 4'd3 || occ_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL nom_accept_k: state=%0d valid=%b required 3/0", state, occ_req_valid);
        end
        occ_rsp_valid = 1; occ_rsp_data = 32'hAAAA0001;
        step(); occ_rsp_valid = 0;
        n_checks++;
        if (state !== 4'd4 || data_1 !== 32'hAAAA0001 || occ_req_valid !== 1'b1 || occ_req_addr !== 8'h34) begin
            n_errors++;
            $display("FAIL nom_req_l: state=%0d d1=%h valid=%b addr=%h required 4/AAAA0001/1/34", state, data_1, occ_req_valid, occ_req_addr);
        end
        step();
        occ_rsp_valid = 1; occ_rsp_data = 32'hBBBB0002;
        step(); occ_rsp_valid = 0;
        n_checks++;
        if (state !== 4'd5 || data_2 !== 32'hBBBB0002) begin
            n_errors++;
            $display("FAIL nom_ex: state=%0d d2=%h required 5/BBBB0002", state, data_2);
        end
        step();
        n_checks++;
        if (state !== 4'd7 || done !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL nom_done: state=%0d done=%b busy=%b required 7/1/0", state, done, busy);
        end
        step();
        n_checks++;
        if (state !== 4'd0 || done !== 1'b0 || iter_cnt !== 16'd0 || data_1 !== 32'hAAAA0001 || data_2 !== 32'hBBBB0002) begin
            n_errors++;
            $display("FAIL nom_idle: state=%0d done=%b iter=%0d d1=%h d2=%h required 0/0/0/AAAA0001/BBBB0002", state, done, iter_cnt, data_1, data_2);
        end
        idle_inputs();
    endtask

    task automatic test_bypass();
        logic [3:0] exp_seq [15];
        logic       seen_valid;
        exp_seq = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd2, 4'd5, 4'd6,
                    4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd7, 4'd0};
        seen_valid = 1'b0;
        is_find = 1; is_get_data_in_Occ = 0; is_finish = 0;
        is_start = 1;
        for (int i = 0; i < 15; i++) begin
            step();
            is_start = 0;
            if (occ_req_valid !== 1'b0) seen_valid = 1'b1;
            n_checks++;
            if (state !== exp_seq[i]) begin
                n_errors++;
                $display("FAIL bypass_seq[%0d]: state=%0d required %0d", i, state, exp_seq[i]);
            end
            if (i == 12) is_find = 0;
        end
        n_checks++;
        if (iter_cnt !== 16'd3 || seen_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bypass_end: iter=%0d valid_seen=%b required 3/0", iter_cnt, seen_valid);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        is_find = 1; is_get_data_in_Occ = 1; is_finish = 1; occ_req_ready = 0;
        is_start = 1;
        step(); is_start = 0;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (state !== 4'd3 || occ_req_valid !== 1'b1 || occ_req_addr !== 8'h12) begin
                n_errors++;
                $display("FAIL bp_hold[%0d]: state=%0d valid=%b addr=%h required 3/1/12", i, state, occ_req_valid, occ_req_addr);
            end
        end
        occ_req_ready = 1; occ_rsp_valid = 1; occ_rsp_data = 32'hDEAD0000;
        step();
        occ_req_ready = 0; occ_rsp_valid = 0;
        n_checks++;
        if (state !== 4'd3 || occ_req_valid !== 1'b0 || data_1 !== 32'h0) begin
            n_errors++;
            $display("FAIL bp_ignore_rsp: state=%0d valid=%b d1=%h required 3/0/00000000", state, occ_req_valid, data_1);
        end
        occ_rsp_valid = 1; occ_rsp_data = 32'hCAFE0003;
        step(); occ_rsp_valid = 0;
        n_checks++;
        if (state !== 4'd4 || data_1 !== 32'hCAFE0003) begin
            n_errors++;
            $display("FAIL bp_latch: state=%0d d1=%h required 4/CAFE0003", state, data_1);
        end
        is_abort = 1;
        step(); is_abort = 0;
        n_checks++;
        if (state !== 4'd0) begin
            n_errors++;
            $display("FAIL bp_cleanup: state=%0d required 0", state);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        is_find = 1; is_get_data_in_Occ = 1; cfg_timeout = 8'd4;
        is_start = 1;
        step(); is_start = 0;
        step(); step();
        step(); step(); step();
        n_checks++;
        if (state !== 4'd3 || occ_req_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL to_still_wait: state=%0d valid=%b required 3/1", state, occ_req_valid);
        end
        step();
        n_checks++;
        if (state !== 4'd8 || err_code !== 2'd1 || occ_req_valid !== 1'b0 || error !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL to_error: state=%0d code=%0d valid=%b error=%b busy=%b required 8/1/0/1/0", state, err_code, occ_req_valid, error, busy);
        end
        is_start = 1;
        step(); is_start = 0;
        n_checks++;
        if (state !== 4'd8 || err_code !== 2'd1) begin
            n_errors++;
            $display("FAIL to_start_ignored: state=%0d code=%0d required 8/1", state, err_code);
        end
        err_clr = 1;
        step(); err_clr = 0;
        n_checks++;
        if (state !== 4'd0 || err_code !== 2'd0 || error !== 1'b0) begin
            n_errors++;
            $display("FAIL to_clear: state=%0d code=%0d error=%b required 0/0/0", state, err_code, error);
        end
        idle_inputs();
    endtask

    task automatic test_iter_limit();
        is_find = 1; is_get_data_in_Occ = 0; is_finish = 0; cfg_max_iter = 16'd2;
        is_start = 1;
        step(); is_start = 0;
        for (int i = 0; i < 7; i++) step();
        n_checks++;
        if (state !== 4'd6 || iter_cnt !== 16'd1) begin
            n_errors++;
            $display("FAIL iter_second_wb: state=%0d iter=%0d required 6/1", state, iter_cnt);
        end
        step();
        n_checks++;
        if (state !== 4'd8 || err_code !== 2'd2 || iter_cnt !== 16'd2) begin
            n_errors++;
            $display("FAIL iter_limit: state=%0d code=%0d iter=%0d required 8/2/2", state, err_code, iter_cnt);
        end
        err_clr = 1;
        step(); err_clr = 0;
        idle_inputs();
    endtask

    task automatic test_abort();
        is_find = 1; is_get_data_in_Occ = 1; is_finish = 1; occ_req_ready = 1;
        is_start = 1;
        step(); is_start = 0;
        step(); step(); step();
        occ_rsp_valid = 1; occ_rsp_data = 32'h11110001;
        step(); occ_rsp_valid = 0;
        is_abort = 1;
        step(); is_abort = 0;
        n_checks++;
        if (state !== 4'd0 || occ_req_valid !== 1'b0 || done !== 1'b0 || data_2 !== 32'h0 || data_1 !== 32'h11110001) begin
            n_errors++;
            $display("FAIL abort_idle: state=%0d valid=%b done=%b d1=%h d2=%h required 0/0/0/11110001/00000000", state, occ_req_valid, done, data_1, data_2);
        end
        step();
        n_checks++;
        if (state !== 4'd0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_no_done: state=%0d done=%b required 0/0", state, done);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        is_find = 1; is_get_data_in_Occ = 1; occ_req_ready = 1;
        is_start = 1;
        step(); is_start = 0;
        step(); step();
        rst_n = 0;
        #1;
        n_checks++;
        if (state !== 4'd0 || occ_req_valid !== 1'b0 || occ_req_addr !== 8'h00 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_async: state=%0d valid=%b addr=%h busy=%b required 0/0/00/0", state, occ_req_valid, occ_req_addr, busy);
        end
        step();
        rst_n = 1;
        step();
        n_checks++;
        if (state !== 4'd0 || occ_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_release: state=%0d valid=%b required 0/0", state, occ_req_valid);
        end
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_nominal();
        test_bypass();
        test_backpressure();
        test_timeout();
        test_iter_limit();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
